multicycle_control_unit: RTL and testbench

Main control FSM for the multicycle RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select.
- Produces the 2-bit ALU class code consumed by the ALU control decoder: 00 load/store add, 01 branch compare, 10 func3/func7 ALU op.
- Sits between the instruction register's opcode field and the datapath; handshakes with memory through a ready signal.

---
 rtl/multicycle_control_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - main control FSM for the multicycle RV32I datapath (optional ILLEGAL_TRAP_EN)
module multicycle_control_unit #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       pc_source_o,
    output logic       lorD_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic [1:0] mem_to_reg_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] ALU_CO_o,
    output logic       is_immediate_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_LUI      = 4'd8,
        S_AUIPC    = 4'd9,
        S_ALUWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12,
`ifdef ILLEGAL_TRAP_EN
        S_JALR     = 4'd13,
        S_TRAP     = 4'd14
`else
        S_JALR     = 4'd13
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t state;
    state_t next_state;
    logic   opcode_legal;

    // Recognised RV32I major opcodes; anything else takes the illegal path in DECODE.
    always_comb begin
        case (opcode_i)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
            default:                            opcode_legal = 1'b0;
        endcase
    end

    // State register; reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= next_state;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky flag raised on the DECODE->TRAP edge, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state == S_DECODE && !opcode_legal) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_o = illegal_q & ~rst;
`else
    assign illegal_o = 1'b0;
`endif

    // Next-state and datapath controls; everything idles at 0 while reset is held.
    always_comb begin
        next_state      = state;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = 1'b0;
        lorD_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        mem_to_reg_o    = 2'b00;
        alu_src_a_o     = 2'b00;
        alu_src_b_o     = 2'b00;
        ALU_CO_o        = 2'b00;
        is_immediate_o  = 1'b0;
        instr_done_o    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // ALUOut captures old-PC + immediate as the branch target.
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b10;
                    case (opcode_i)
                        OP_LOAD, OP_STORE: next_state = S_MEMADR;
                        OP_R:              next_state = S_EXEC_R;
                        OP_I:              next_state = S_EXEC_I;
                        OP_BRANCH:         next_state = S_BRANCH;
                        OP_JAL:            next_state = S_JAL;
                        OP_JALR:           next_state = S_JALR;
                        OP_LUI:            next_state = S_LUI;
                        OP_AUIPC:          next_state = S_AUIPC;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            next_state = S_TRAP;
`else
                            instr_done_o = 1'b1;
                            next_state   = S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b10;
                    next_state  = (opcode_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    mem_read_o = 1'b1;
                    lorD_o     = 1'b1;
                    if (mem_ready_i) next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'b01;
                    instr_done_o = 1'b1;
                    next_state   = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_write_o = 1'b1;
                    lorD_o      = 1'b1;
                    if (mem_ready_i) begin
                        instr_done_o = 1'b1;
                        next_state   = S_FETCH;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a_o = 2'b10;
                    ALU_CO_o    = 2'b10;
                    next_state  = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a_o    = 2'b10;
                    alu_src_b_o    = 2'b10;
                    ALU_CO_o       = 2'b10;
                    is_immediate_o = 1'b1;
                    next_state     = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_a_o = 2'b11;
                    alu_src_b_o = 2'b10;
                    next_state  = S_ALUWB;
                end
                S_AUIPC: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b10;
                    next_state  = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                    next_state   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a_o     = 2'b10;
                    ALU_CO_o        = 2'b01;
                    pc_write_cond_o = 1'b1;
                    pc_source_o     = 1'b1;
                    instr_done_o    = 1'b1;
                    next_state      = S_FETCH;
                end
                S_JAL, S_JALR: begin
                    // Link write sees PC+4 while the PC takes the target on the same edge.
                    alu_src_a_o  = (state == S_JAL) ? 2'b01 : 2'b10;
                    alu_src_b_o  = 2'b10;
                    pc_write_o   = 1'b1;
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'b10;
                    instr_done_o = 1'b1;
                    next_state   = S_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: begin
                    next_state = S_TRAP;
                end
`endif
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_source, lord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_co;
    logic       is_immediate, instr_done, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_unit dut (
        .clk             (clk),
        .rst             (rst),
        .opcode_i        (opcode),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .pc_source_o     (pc_source),
        .lorD_o          (lord),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .reg_write_o     (reg_write),
        .mem_to_reg_o    (mem_to_reg),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .ALU_CO_o        (alu_co),
        .is_immediate_o  (is_immediate),
        .instr_done_o    (instr_done),
        .illegal_o       (illegal)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {pc_write, pc_write_cond, pc_source, lord, mem_read, mem_write, ir_write, reg_write,
                  mem_to_reg, alu_src_a, alu_src_b, alu_co, is_immediate, instr_done, illegal};

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0] legal_ops [9] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
                                  OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    // Expected output word in the same field order as obs.
    function automatic logic [18:0] ow(input logic pcw, pcc, pcs, lo, mr, mw, irw, rw,
                                       input logic [1:0] m2r, sa, sb, co,
                                       input logic imm, done, ill);
        return {pcw, pcc, pcs, lo, mr, mw, irw, rw, m2r, sa, sb, co, imm, done, ill};
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] any_op();
        return 7'($urandom);
    endfunction

    function automatic logic any_bit();
        return 1'($urandom);
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, advance past the next edge.
    task automatic cyc(input string tag, input logic [6:0] op, input logic rdy, input logic [18:0] exp);
        opcode    = op;
        mem_ready = rdy;
        @(negedge clk);
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        cyc("reset", any_op(), any_bit(), '0);
        rst = 1'b0;
    endtask

    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            cyc("fetch_wait", any_op(), 1'b0, ow(0,0,0,0,1,0,0,0, 2'd0,2'd0,2'd1,2'd0, 0,0,0));
        cyc("fetch", any_op(), 1'b1, ow(1,0,0,0,1,0,1,0, 2'd0,2'd0,2'd1,2'd0, 0,0,0));
    endtask

    // Full instruction from FETCH; opcode is presented only where the FSM is allowed to use it.
    task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait);
        logic [18:0] dec;
        dec = ow(0,0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0, 0,0,0);
        do_fetch(fwait);
        if (!is_legal(op)) begin
`ifdef ILLEGAL_TRAP_EN
            cyc("decode_illegal", op, any_bit(), dec);
            for (int i = 0; i < 3; i++)
                cyc("trap", any_op(), any_bit(), ow(0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,1));
            reset_cycle();
`else
            cyc("decode_nop", op, any_bit(), dec | 19'd2);
`endif
            return;
        end
        cyc("decode", op, any_bit(), dec);
        case (op)
            OP_LOAD: begin
                cyc("memadr", op, any_bit(), ow(0,0,0,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0,0,0));
                for (int i = 0; i <= mwait; i++)
                    cyc("memread", any_op(), i == mwait, ow(0,0,0,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,0));
                cyc("memwb", any_op(), any_bit(), ow(0,0,0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0, 0,1,0));
            end
            OP_STORE: begin
                cyc("memadr", op, any_bit(), ow(0,0,0,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0,0,0));
                for (int i = 0; i < mwait; i++)
                    cyc("memwrite_wait", any_op(), 1'b0, ow(0,0,0,1,0,1,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,0));
                cyc("memwrite", any_op(), 1'b1, ow(0,0,0,1,0,1,0,0, 2'd0,2'd0,2'd0,2'd0, 0,1,0));
            end
            OP_BRANCH:
                cyc("branch", any_op(), any_bit(), ow(0,1,1,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd1, 0,1,0));
            OP_JAL:
                cyc("jal", any_op(), any_bit(), ow(1,0,0,0,0,0,0,1, 2'd2,2'd1,2'd2,2'd0, 0,1,0));
            OP_JALR:
                cyc("jalr", any_op(), any_bit(), ow(1,0,0,0,0,0,0,1, 2'd2,2'd2,2'd2,2'd0, 0,1,0));
            default: begin
                case (op)
                    OP_R:     cyc("exec_r", any_op(), any_bit(), ow(0,0,0,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2, 0,0,0));
                    OP_I:     cyc("exec_i", any_op(), any_bit(), ow(0,0,0,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd2, 1,0,0));
                    OP_LUI:   cyc("lui",    any_op(), any_bit(), ow(0,0,0,0,0,0,0,0, 2'd0,2'd3,2'd2,2'd0, 0,0,0));
                    default:  cyc("auipc",  any_op(), any_bit(), ow(0,0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0, 0,0,0));
                endcase
                cyc("aluwb", any_op(), any_bit(), ow(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 0,1,0));
            end
        endcase
    endtask

    // Start a memory instruction, abort it with reset during the memory wait.
    task automatic abort_mem(input logic [6:0] op);
        do_fetch(0);
        cyc("abort_decode", op, 1'b1, ow(0,0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0, 0,0,0));
        cyc("abort_memadr", op, 1'b1, ow(0,0,0,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0,0,0));
        if (op == OP_STORE)
            cyc("abort_memwrite", any_op(), 1'b0, ow(0,0,0,1,0,1,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,0));
        else
            cyc("abort_memread", any_op(), 1'b0, ow(0,0,0,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,0));
        reset_cycle();
    endtask

    initial begin
        logic [6:0] op;
        rst       = 1'b1;
        opcode    = '0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_cycle();

        run_instr(OP_R, 0, 0);
        run_instr(OP_LOAD, 0, 2);
        run_instr(OP_BRANCH, 0, 0);
        run_instr(OP_JAL, 0, 0);
        run_instr(OP_LUI, 0, 0);
        run_instr(7'b1111111, 0, 0);
        abort_mem(OP_STORE);
        run_instr(OP_STORE, 1, 1);
        abort_mem(OP_LOAD);
        run_instr(OP_I, 2, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = any_op(); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) reset_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
